// File: rtl/p_box_if.sv
// Valid-strobed 48-bit data bus for the P-box.
// The master drives the input word; the slave returns the permuted word.
interface p_box_if;
  logic        in_valid;
  logic [47:0] data;
  logic        out_valid;
  logic [47:0] permutation;

  modport master (output in_valid, output data, input out_valid, input permutation);
  modport slave  (input in_valid, input data, output out_valid, output permutation);
endinterface

// File: rtl/p_box.sv
// MacGuffin round-function P-box: fixed 48-bit bit scatter.
// The output is optionally registered behind a valid strobe.
module p_box #(
  parameter int unsigned REG_OUT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  p_box_if.slave  bus
);

  logic [47:0] d;
  logic [47:0] p_w;

  assign d = bus.data;

  // Pure wiring, MSB first; output bit k takes data bit listed at position 47-k.
  assign p_w = {
    d[45], d[42], d[25], d[22], d[4],  d[2],
    d[46], d[43], d[24], d[21], d[7],  d[1],
    d[44], d[41], d[23], d[18], d[15], d[0],
    d[35], d[33], d[30], d[29], d[11], d[5],
    d[47], d[37], d[28], d[17], d[9],  d[3],
    d[40], d[39], d[19], d[16], d[14], d[10],
    d[38], d[32], d[26], d[20], d[13], d[8],
    d[36], d[34], d[31], d[27], d[12], d[6]
  };

  generate
    if (REG_OUT != 0) begin : g_reg
      logic        valid_q, valid_d;
      logic [47:0] perm_q,  perm_d;

      always_comb begin
        valid_d = bus.in_valid;
        perm_d  = perm_q;
        if (bus.in_valid) perm_d = p_w;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          perm_q  <= '0;
        end else begin
          valid_q <= valid_d;
          perm_q  <= perm_d;
        end
      end

      assign bus.out_valid   = valid_q;
      assign bus.permutation = perm_q;
    end else begin : g_comb
      assign bus.out_valid   = bus.in_valid;
      assign bus.permutation = p_w;
    end
  endgenerate

endmodule

// File: tb/tb_p_box.sv
// Self-checking bench for p_box (registered mode): vector table plus
// multi-cycle sequences, with expected words queued at drive time.
module tb_p_box;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p_box_if bus();

  p_box #(.REG_OUT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Source bit for each output bit, listed from output bit 47 down to 0.
  localparam int SRC [48] = '{
    45, 42, 25, 22,  4,  2,
    46, 43, 24, 21,  7,  1,
    44, 41, 23, 18, 15,  0,
    35, 33, 30, 29, 11,  5,
    47, 37, 28, 17,  9,  3,
    40, 39, 19, 16, 14, 10,
    38, 32, 26, 20, 13,  8,
    36, 34, 31, 27, 12,  6
  };

  function automatic logic [47:0] ref_p(input logic [47:0] x);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 48; k++) r[47 - k] = x[SRC[k]];
    return r;
  endfunction

  typedef struct {
    logic        v;
    logic [47:0] d;
    logic [47:0] e;
  } vec_t;

  vec_t        vecs[$];
  logic [47:0] sbq[$];
  logic [47:0] last_exp;
  int          total = 0;
  int          bad   = 0;

  function automatic void chk(input string n, input logic [47:0] a, input logic [47:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endfunction

  task automatic step(input logic v, input logic [47:0] d, input logic [47:0] e);
    logic [47:0] x;
    @(negedge clk);
    bus.in_valid = v;
    bus.data     = d;
    if (v) sbq.push_back(e);
    @(posedge clk);
    #1;
    chk("out_valid", {47'd0, bus.out_valid}, {47'd0, v});
    if (v) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 48'd1, 48'd0);
      end else begin
        x = sbq.pop_front();
        last_exp = x;
        chk("permutation", bus.permutation, x);
      end
    end else begin
      chk("hold", bus.permutation, last_exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] a, w;
    bus.in_valid = 1'b0;
    bus.data     = '0;
    last_exp     = '0;

    // Reset state, held before any clock edge matters.
    #3;
    chk("reset_valid", {47'd0, bus.out_valid}, 48'd0);
    chk("reset_perm", bus.permutation, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand constants first, then the one-hot walk with complements from the model.
    vecs.push_back('{1'b1, 48'd1 << 0,  48'd1 << 30});
    vecs.push_back('{1'b1, 48'd1 << 45, 48'd1 << 47});
    vecs.push_back('{1'b1, 48'd1 << 47, 48'd1 << 23});
    vecs.push_back('{1'b1, 48'd1 << 6,  48'd1 << 0});
    vecs.push_back('{1'b1, 48'h0, 48'h0});
    vecs.push_back('{1'b1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF});
    for (int i = 0; i < 48; i++) begin
      a = 48'd1 << i;
      vecs.push_back('{1'b1, a, ref_p(a)});
      vecs.push_back('{1'b1, ~a, ~ref_p(a)});
    end
    foreach (vecs[i]) step(vecs[i].v, vecs[i].d, vecs[i].e);

    // Random words with popcount preservation.
    for (int i = 0; i < 100; i++) begin
      a = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(1'b1, a, ref_p(a));
      chk("popcount", 48'($countones(bus.permutation)), 48'($countones(a)));
    end

    // Streaming: ten back-to-back words then idle.
    step(1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      a = {16'($urandom), 16'(i), 16'($urandom)};
      step(1'b1, a, ref_p(a));
    end
    step(1'b0, 48'hDEAD_BEEF_0000, '0);

    // Gaps: 1,0,1,0 with hold across the idle cycles.
    a = 48'h1234_5678_9ABC;
    step(1'b1, a, ref_p(a));
    step(1'b0, 48'hFFFF_0000_FFFF, '0);
    a = 48'hA5A5_0F0F_3C3C;
    step(1'b1, a, ref_p(a));
    step(1'b0, 48'h0, '0);

    // Asynchronous reset mid-stream, between clock edges.
    a = 48'h0F0F_F0F0_AAAA;
    step(1'b1, a, ref_p(a));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data     = 48'h5555_3333_CCCC;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {47'd0, bus.out_valid}, 48'd0);
    chk("async_reset_perm", bus.permutation, 48'd0);
    sbq.delete();
    last_exp = '0;
    @(posedge clk);
    #1;
    chk("reset_held_valid", {47'd0, bus.out_valid}, 48'd0);
    chk("reset_held_perm", bus.permutation, 48'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    w = 48'hC0FF_EE12_3456;
    step(1'b1, w, ref_p(w));
    step(1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
